alu_test_seq: RTL and testbench
===============================

ALU_TEST_SEQ -- requirements
Module: alu_test_seq

Interface
REQ-001 Parameter WIDTH, default 32: ALU operand/result width in bits.
REQ-002 Parameter SW_W, default 4: switch/LED width; WIDTH SHALL be a multiple of SW_W; NCHUNK = WIDTH/SW_W.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stable-sample count, used only when debounce is compiled in.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 sw  in  SW_W: data chunk or opcode entry.
REQ-007 btn  in  4: raw buttons; 0 = write chunk, 1 = next stage, 2 = clear, 3 = next display chunk.
REQ-008 operandA, operandB  out  WIDTH: registered operands to an external ALU.
REQ-009 command  out  3: registered ALU opcode.
REQ-010 result  in  WIDTH; carryout, zero, overflow  in  1 each: from the external combinational ALU.
REQ-011 led  out  SW_W: display chunk.
REQ-012 flags  out  3: latched {overflow, zero, carryout}.
REQ-013 stage  out  2: current FSM state encoding.

Function
REQ-014 FSM states, encoded 0..3: LOAD_A, LOAD_B, LOAD_OP, SHOW.
REQ-015 Each button press SHALL produce exactly one single-cycle press pulse, generated on the 0->1 transition of the conditioned level.
REQ-016 Press priority SHALL be btn2 > btn1 > btn0 > btn3; at most one action per cycle, and lower-priority presses in the same cycle are dropped.
REQ-017 btn2 in any state: go to LOAD_A; clear operands, command, chunk pointer ptr, latched result and flags.
REQ-018 btn0 in LOAD_A/LOAD_B: write sw into chunk ptr (bits ptr*SW_W+SW_W-1 : ptr*SW_W) of operandA/operandB; ptr increments modulo NCHUNK, wrapping to 0 and overwriting earlier chunks.
REQ-019 btn0 in LOAD_OP: command <= sw[2:0]; sw[SW_W-1:3] are ignored; ptr unchanged.
REQ-020 btn1: LOAD_A->LOAD_B->LOAD_OP->SHOW->LOAD_A; ptr <= 0 on every transition.
REQ-021 btn1 in LOAD_OP: on that same edge, latch result and flags into internal registers; the values then SHALL hold until the next clear, reset or capture.
REQ-022 btn1 in SHOW->LOAD_A: operands and command retained, so they can be re-edited chunk-wise.
REQ-023 btn3 in SHOW: ptr increments modulo NCHUNK; in other states, ignored.
REQ-024 led: sw in LOAD_A/LOAD_B; {zero-pad, command} in LOAD_OP; latched result chunk ptr in SHOW. Registered, so it updates one cycle after its source changes.
REQ-025 Edits to operands or command SHALL NOT alter the latched result or flags.

Reset
REQ-026 While reset is high on a clock edge: state LOAD_A, ptr 0, operandA/operandB/command/led/flags/latched result 0, all conditioning registers 0.
REQ-027 Reset mid-sequence SHALL discard partial entries; a button held through reset release SHALL NOT generate a press.

Configuration
REQ-028 Macro ALU_TEST_SEQ_DEBOUNCE_EN defined: a button level is accepted only after DEBOUNCE_CYCLES consecutive identical samples, after a 2-flop synchroniser; press latency = 2 + DEBOUNCE_CYCLES cycles.
REQ-029 Macro undefined: 2-flop synchroniser plus edge detect only; press latency = 3 cycles from the btn rise to the action edge.

Structure
REQ-030 Package alu_test_pkg SHALL hold the state enum, opcode width constant (3), flag bit indices, and button index constants.
REQ-031 Sub-module btn_conditioner (synchroniser, optional debounce, edge detect; 1-bit in, level and pulse out) SHALL be instantiated once per button.

Verification
REQ-032 WIDTH=8, SW_W=4: in LOAD_A press btn0 with sw=0x5, then with sw=0xA -> operandA=0xA5; a third btn0 with sw=0x3 -> operandA=0xA3 (wrap).
REQ-033 Load A=0x0F, B=0x01, command=0 (add), btn1 -> SHOW; led=0x0 at ptr0; after btn3 led=0x1; after btn3 again led=0x0; flags=000.
REQ-034 In SHOW, edit nothing; assert btn2 with btn1 and btn0 in the same cycle -> only the clear happens: state LOAD_A, all registers 0.
REQ-035 Assert reset for one cycle after two chunk writes in LOAD_B -> all outputs 0, stage=0; a button held across reset release produces no write.
REQ-036 With debounce enabled (DEBOUNCE_CYCLES=4): a btn0 glitch of 3 cycles -> no write; a 5-cycle press -> exactly one write, landing 6 cycles after the btn rise.
REQ-037 Opcode sw=0xF in LOAD_OP -> command=3'b111, led=4'b0111.

Source files
------------

// File: rtl/alu_test_seq_pkg.sv
// alu_test_pkg: shared state encoding, opcode width, flag and button indices for alu_test_seq.
package alu_test_pkg;
   localparam int OP_W     = 3;
   localparam int FLAG_C   = 0;
   localparam int FLAG_Z   = 1;
   localparam int FLAG_V   = 2;
   localparam int BTN_WR   = 0;
   localparam int BTN_NEXT = 1;
   localparam int BTN_CLR  = 2;
   localparam int BTN_DISP = 3;
   typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_OP = 2'd2, SHOW = 2'd3} state_t;
endpackage

// File: rtl/alu_test_seq_btn_conditioner.sv
// btn_conditioner: 2-flop synchroniser, optional debounce (ALU_TEST_SEQ_DEBOUNCE_EN), one-cycle press pulse.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);
   logic r_s1, r_s2, r_valid, r_armed, w_rise;
   // a button already held when reset releases stays disarmed until it is seen low
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_valid <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_valid <= 1'b1;
         r_armed <= r_armed | (r_valid & ~r_s1);
      end
   end
`ifdef ALU_TEST_SEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_level, w_accept;
   assign w_accept = (r_s2 != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (r_s2 == r_level) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_level <= r_s2;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
   assign w_rise  = w_accept & r_s2;
   assign o_level = r_level;
`else
   logic r_prev;
   always_ff @(posedge clk) r_prev <= reset ? 1'b0 : r_s2;
   assign w_rise  = r_s2 & ~r_prev;
   assign o_level = r_s2;
`endif
   assign o_press = w_rise & r_armed;
endmodule

// File: rtl/alu_test_seq.sv
// alu_test_seq: button/switch front end that loads operands and opcode for an external ALU and shows the result.
// Define ALU_TEST_SEQ_DEBOUNCE_EN to add per-button debouncing.
module alu_test_seq
   import alu_test_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int SW_W            = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SW_W-1:0]  sw,
   input  logic [3:0]       btn,
   output logic [WIDTH-1:0] operandA,
   output logic [WIDTH-1:0] operandB,
   output logic [OP_W-1:0]  command,
   input  logic [WIDTH-1:0] result,
   input  logic             carryout,
   input  logic             zero,
   input  logic             overflow,
   output logic [SW_W-1:0]  led,
   output logic [2:0]       flags,
   output logic [1:0]       stage
);
   localparam int NCHUNK = WIDTH / SW_W;
   localparam int PW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   state_t           r_state, w_next;
   logic [PW-1:0]    r_ptr, w_ptr_inc;
   logic [WIDTH-1:0] r_res;
   logic [2:0]       r_flags;
   logic [SW_W-1:0]  r_led;
   logic [3:0]       w_press, w_level_unused;
   logic             w_clr, w_nxt, w_wr, w_disp, w_load;
   for (genvar b = 0; b < 4; b++) begin : g_btn
      btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
         .clk     (clk),
         .reset   (reset),
         .i_btn   (btn[b]),
         .o_level (w_level_unused[b]),
         .o_press (w_press[b])
      );
   end
   // one action per cycle: clear > next > write > display
   assign w_clr     = w_press[BTN_CLR];
   assign w_nxt     = w_press[BTN_NEXT] & ~w_clr;
   assign w_wr      = w_press[BTN_WR] & ~w_clr & ~w_press[BTN_NEXT];
   assign w_disp    = w_press[BTN_DISP] & ~w_clr & ~w_nxt & ~w_wr;
   assign w_load    = (r_state == LOAD_A) || (r_state == LOAD_B);
   assign w_ptr_inc = (r_ptr == PW'(NCHUNK - 1)) ? '0 : r_ptr + 1'b1;
   always_ff @(posedge clk) begin
      if (reset) r_state <= LOAD_A;
      else       r_state <= w_next;
   end
   always_comb begin
      w_next = w_clr ? LOAD_A : w_nxt ? state_t'(r_state + 2'd1) : r_state;
   end
   always_ff @(posedge clk) begin
      if (reset || w_clr) begin
         operandA <= '0;
         operandB <= '0;
         command  <= '0;
         r_ptr    <= '0;
         r_res    <= '0;
         r_flags  <= '0;
         r_led    <= '0;
      end else begin
         if (w_wr && r_state == LOAD_A) operandA[r_ptr*SW_W +: SW_W] <= sw;
         if (w_wr && r_state == LOAD_B) operandB[r_ptr*SW_W +: SW_W] <= sw;
         if (w_wr && r_state == LOAD_OP) command <= sw[OP_W-1:0];
         if (w_nxt && r_state == LOAD_OP) begin
            r_res           <= result;
            r_flags[FLAG_C] <= carryout;
            r_flags[FLAG_Z] <= zero;
            r_flags[FLAG_V] <= overflow;
         end
         r_ptr <= w_nxt ? '0 : ((w_wr && w_load) || (w_disp && r_state == SHOW)) ? w_ptr_inc : r_ptr;
         r_led <= (r_state == LOAD_OP) ? SW_W'(command) : (r_state == SHOW) ? r_res[r_ptr*SW_W +: SW_W] : sw;
      end
   end
   assign led   = r_led;
   assign flags = r_flags;
   assign stage = r_state;
endmodule

// File: tb/tb_alu_test_seq.sv
// tb_alu_test_seq: directed self-checking bench for alu_test_seq with a behavioural ALU attached.
module tb_alu_test_seq;
`ifdef ALU_TEST_SEQ_DEBOUNCE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 3;
`endif
   logic       clk = 1'b0, reset;
   logic [3:0] sw, btn, led;
   logic [7:0] operandA, operandB, result;
   logic [2:0] command, flags;
   logic [1:0] stage;
   logic [8:0] sum;
   logic       carryout, zero, overflow;
   int         n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   assign sum      = command == 3'd0 ? {1'b0, operandA} + {1'b0, operandB} :
                     command == 3'd1 ? {1'b0, operandA} - {1'b0, operandB} : {1'b0, operandA & operandB};
   assign result   = sum[7:0];
   assign carryout = sum[8];
   assign zero     = result == 8'd0;
   assign overflow = command == 3'd0 ? (operandA[7] == operandB[7]) && (result[7] != operandA[7]) :
                     command == 3'd1 ? (operandA[7] != operandB[7]) && (result[7] != operandA[7]) : 1'b0;
   alu_test_seq #(.WIDTH(8), .SW_W(4), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .sw(sw), .btn(btn),
      .operandA(operandA), .operandB(operandB), .command(command),
      .result(result), .carryout(carryout), .zero(zero), .overflow(overflow),
      .led(led), .flags(flags), .stage(stage)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic press(input logic [3:0] m);
      btn = m;
      repeat (LAT + 1) @(negedge clk);
      btn = 4'b0;
      repeat (LAT + 3) @(negedge clk);
   endtask
   task automatic wr(input logic [3:0] v);
      sw = v;
      press(4'b0001);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1; btn = 4'b0; sw = 4'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_stage", stage, 0);
      check("rst_opA", operandA, 0);
      check("rst_opB", operandB, 0);
      check("rst_cmd", command, 0);
      check("rst_led", led, 0);
      check("rst_flags", flags, 0);
      wr(4'h5);
      wr(4'hA);
      check("opA_A5", operandA, 8'hA5);
      wr(4'h3);
      check("opA_wrap", operandA, 8'hA3);
      check("led_sw", led, 4'h3);
      sw = 4'h0;
      press(4'b0100);
      check("clr_opA", operandA, 0);
      wr(4'hF);
      wr(4'h0);
      check("opA_0F", operandA, 8'h0F);
      press(4'b0010);
      check("stage_b", stage, 1);
      wr(4'h1);
      wr(4'h0);
      check("opB_01", operandB, 8'h01);
      press(4'b0010);
      check("stage_op", stage, 2);
      wr(4'h0);
      check("cmd_add", command, 0);
      press(4'b0010);
      check("stage_show", stage, 3);
      check("show_led0", led, 4'h0);
      check("flags_000", flags, 3'b000);
      press(4'b1000);
      check("show_led1", led, 4'h1);
      press(4'b1000);
      check("show_led0_wrap", led, 4'h0);
      press(4'b0010);
      check("retain_opA", operandA, 8'h0F);
      check("retain_opB", operandB, 8'h01);
      wr(4'hF);
      wr(4'hF);
      check("opA_FF", operandA, 8'hFF);
      check("flags_hold", flags, 3'b000);
      press(4'b0010);
      press(4'b0010);
      press(4'b0010);
      check("stage_show2", stage, 3);
      check("flags_011", flags, 3'b011);
      check("show2_led0", led, 4'h0);
      sw = 4'h0;
      press(4'b0111);
      check("pri_stage", stage, 0);
      check("pri_opA", operandA, 0);
      check("pri_opB", operandB, 0);
      check("pri_cmd", command, 0);
      check("pri_flags", flags, 0);
      check("pri_led", led, 0);
      press(4'b0010);
      press(4'b0010);
      wr(4'hF);
      check("cmd_111", command, 3'b111);
      check("led_cmd", led, 4'b0111);
      press(4'b0100);
      press(4'b0010);
      wr(4'h3);
      wr(4'h4);
      check("opB_43", operandB, 8'h43);
      sw = 4'hE; btn = 4'b0001; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_stage", stage, 0);
      check("mrst_opB", operandB, 0);
      check("mrst_cmd", command, 0);
      check("mrst_led", led, 0);
      check("mrst_flags", flags, 0);
      repeat (LAT + 3) @(negedge clk);
      check("held_no_write", operandA, 0);
      btn = 4'b0;
      repeat (LAT + 3) @(negedge clk);
      wr(4'h9);
      check("post_rst_write", operandA, 8'h09);
`ifdef ALU_TEST_SEQ_DEBOUNCE_EN
      sw = 4'h6; btn = 4'b0001;
      repeat (3) @(negedge clk);
      btn = 4'b0;
      repeat (12) @(negedge clk);
      check("glitch_no_write", operandA, 8'h09);
      btn = 4'b0001;
      repeat (5) @(negedge clk);
      btn = 4'b0;
      check("db_lat_before", operandA, 8'h09);
      @(negedge clk);
      check("db_lat_at", operandA, 8'h69);
`else
      sw = 4'h6; btn = 4'b0001;
      repeat (2) @(negedge clk);
      check("lat_before", operandA, 8'h09);
      @(negedge clk);
      check("lat_at", operandA, 8'h69);
      btn = 4'b0;
`endif
      repeat (LAT + 3) @(negedge clk);
      check("single_write", operandA, 8'h69);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
